shift_add_mult: RTL and testbench

Parametrised sequential shift-and-add multiplier. It replaces the fixed 4x4 unsigned multiplier with configurable operand widths, an optional signed (two's-complement) mode, a Busy/Done handshake and a registered product output. The block computes one multiplier bit per cycle, so any operand width has a fixed, known latency. It is used wherever area matters more than throughput, for example in the ALU datapath labs.

---
 rtl/shift_add_pkg.sv | 26 ++
 rtl/cond_negate.sv | 26 ++
 rtl/shift_add_mult.sv | 130 +++++++++++++
 tb/tb_shift_add_mult.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_pkg.sv
// ============================================================================
//  Module      : shift_add_pkg
//  Description : Shared state encoding and sizing helper for the sequential
//                shift-and-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_add_pkg;

    // Controller states; every 2-bit code is a legal state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Width of a counter that must hold the value n (counts n down to 1).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cond_negate.sv
// ============================================================================
//  Module      : cond_negate
//  Description : Combinational conditional two's-complement negation with
//                W-bit wraparound. Used for operand magnitudes and for the
//                final product sign correction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_negate #(
    parameter int W = 4
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    // Invert-and-increment; -(2^(W-1)) maps onto itself, which read as an
    // unsigned value is exactly its magnitude.
    assign o_val = i_neg ? (~i_val + C_ONE) : i_val;

endmodule

`default_nettype wire

// File: rtl/shift_add_mult.sv
// ============================================================================
//  Module      : shift_add_mult
//  Description : Parametrised sequential shift-and-add multiplier, one
//                multiplier bit per cycle, optional signed mode, Busy/Done
//                handshake and registered product.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mult
    import shift_add_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             St,
    input  logic             Signed,
    input  logic [N-1:0]     Mplier,
    input  logic [M-1:0]     Mcand,
    output logic             Busy,
    output logic             Done,
    output logic [N+M-1:0]   Product
);

    localparam int CW = cnt_width(N);

    state_e             r_state_q,  r_state_d;
    logic [N+M:0]       r_acc_q,    r_acc_d;
    logic [M-1:0]       r_mcand_q,  r_mcand_d;
    logic               r_neg_q,    r_neg_d;
    logic [CW-1:0]      r_cnt_q,    r_cnt_d;
    logic [N+M-1:0]     r_prod_q,   r_prod_d;

    logic [N-1:0]       w_mplier_mag;
    logic [M-1:0]       w_mcand_mag;
    logic [N+M-1:0]     w_prod_fix;
    logic [M:0]         w_addend;
    logic [M:0]         w_sum;

    // Operand magnitudes; only taken in signed mode with the sign bit set.
    cond_negate #(.W(N)) u_abs_mplier (
        .i_neg (Signed & Mplier[N-1]),
        .i_val (Mplier),
        .o_val (w_mplier_mag)
    );

    cond_negate #(.W(M)) u_abs_mcand (
        .i_neg (Signed & Mcand[M-1]),
        .i_val (Mcand),
        .o_val (w_mcand_mag)
    );

    // Sign fix of the unsigned magnitude product; zero stays zero.
    cond_negate #(.W(N+M)) u_fix (
        .i_neg (r_neg_q),
        .i_val (r_acc_q[N+M-1:0]),
        .o_val (w_prod_fix)
    );

    // Upper half plus the gated multiplicand; the guard bit is always 0 here,
    // so the M+1-bit sum cannot overflow.
    assign w_addend = r_acc_q[0] ? {1'b0, r_mcand_q} : '0;
    assign w_sum    = r_acc_q[N+M:N] + w_addend;

    // Next-state and datapath update for the controller.
    always_comb begin
        r_state_d = r_state_q;
        r_acc_d   = r_acc_q;
        r_mcand_d = r_mcand_q;
        r_neg_d   = r_neg_q;
        r_cnt_d   = r_cnt_q;
        r_prod_d  = r_prod_q;
        case (r_state_q)
            S_IDLE: begin
                if (St) begin
                    r_acc_d   = {{(M+1){1'b0}}, w_mplier_mag};
                    r_mcand_d = w_mcand_mag;
                    r_neg_d   = Signed & (Mplier[N-1] ^ Mcand[M-1]);
                    r_cnt_d   = CW'(N);
                    r_state_d = S_CALC;
                end
            end
            S_CALC: begin
                r_acc_d = {1'b0, w_sum, r_acc_q[N-1:1]};
                r_cnt_d = r_cnt_q - 1'b1;
                if (r_cnt_q == CW'(1)) begin
                    r_state_d = S_FIX;
                end
            end
            S_FIX: begin
                r_prod_d  = w_prod_fix;
                r_state_d = S_DONE;
            end
            S_DONE: begin
                r_state_d = S_IDLE;
            end
            default: begin
                r_state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset (also aborts).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_acc_q   <= '0;
            r_mcand_q <= '0;
            r_neg_q   <= 1'b0;
            r_cnt_q   <= '0;
            r_prod_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_acc_q   <= r_acc_d;
            r_mcand_q <= r_mcand_d;
            r_neg_q   <= r_neg_d;
            r_cnt_q   <= r_cnt_d;
            r_prod_q  <= r_prod_d;
        end
    end

    assign Busy    = (r_state_q == S_CALC) || (r_state_q == S_FIX) || (r_state_q == S_DONE);
    assign Done    = (r_state_q == S_DONE);
    assign Product = r_prod_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult.sv
// ============================================================================
//  Module      : tb_shift_add_mult
//  Description : Self-checking bench for shift_add_mult at 4x4, 8x8 and 4x6
//                operand widths against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st  = '0;
    logic [2:0]  sg  = '0;
    logic [3:0]  mp0 = '0;
    logic [3:0]  mc0 = '0;
    logic [7:0]  mp1 = '0;
    logic [7:0]  mc1 = '0;
    logic [3:0]  mp2 = '0;
    logic [5:0]  mc2 = '0;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [7:0]  p0;
    logic [15:0] p1;
    logic [9:0]  p2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    shift_add_mult #(.N(4), .M(4)) u_dut0 (
        .clk(clk), .rst(rst), .St(st[0]), .Signed(sg[0]), .Mplier(mp0), .Mcand(mc0),
        .Busy(busy[0]), .Done(done[0]), .Product(p0)
    );
    shift_add_mult #(.N(8), .M(8)) u_dut1 (
        .clk(clk), .rst(rst), .St(st[1]), .Signed(sg[1]), .Mplier(mp1), .Mcand(mc1),
        .Busy(busy[1]), .Done(done[1]), .Product(p1)
    );
    shift_add_mult #(.N(4), .M(6)) u_dut2 (
        .clk(clk), .rst(rst), .St(st[2]), .Signed(sg[2]), .Mplier(mp2), .Mcand(mc2),
        .Busy(busy[2]), .Done(done[2]), .Product(p2)
    );

    function automatic int nbits(input int w);
        return (w == 1) ? 8 : 4;
    endfunction

    function automatic int mbits(input int w);
        return (w == 0) ? 4 : ((w == 1) ? 8 : 6);
    endfunction

    function automatic longint prod_of(input int w);
        case (w)
            0:       return longint'(p0);
            1:       return longint'(p1);
            default: return longint'(p2);
        endcase
    endfunction

    // Reference: interpret operands, multiply as integers, keep N+M bits.
    function automatic longint model(input int w, input bit s, input longint a, input longint b);
        longint x, y;
        int n, m;
        n = nbits(w);
        m = mbits(w);
        x = a & ((64'sd1 <<< n) - 1);
        y = b & ((64'sd1 <<< m) - 1);
        if (s && x >= (64'sd1 <<< (n - 1))) x = x - (64'sd1 <<< n);
        if (s && y >= (64'sd1 <<< (m - 1))) y = y - (64'sd1 <<< m);
        return (x * y) & ((64'sd1 <<< (n + m)) - 1);
    endfunction

    task automatic set_ops(input int w, input bit s, input longint a, input longint b);
        sg[w] = s;
        case (w)
            0:       begin mp0 = 4'(a); mc0 = 4'(b); end
            1:       begin mp1 = 8'(a); mc1 = 8'(b); end
            default: begin mp2 = 4'(a); mc2 = 6'(b); end
        endcase
    endtask

    // One-shot St pulse, then scrambled operands; reports latency (negedges
    // after the accepting edge until Done), Busy count and the product.
    task automatic run_op(input int w, input bit s, input longint a, input longint b,
                          output int lat, output int nbusy, output longint prod);
        @(negedge clk);
        set_ops(w, s, a, b);
        st[w] = 1'b1;
        @(negedge clk);
        st[w] = 1'b0;
        set_ops(w, 1'($urandom), longint'($urandom), longint'($urandom));
        lat   = 1;
        nbusy = 0;
        while (1) begin
            if (busy[w]) nbusy++;
            if (done[w] || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
        prod = prod_of(w);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({busy, done} !== 6'b0) $display("FAIL reset_flags: got %b required 0", {busy, done});
        else n_pass++;
        n_total++;
        if ({p0, p1, p2} !== 34'b0) $display("FAIL reset_product: got %h required 0", {p0, p1, p2});
        else n_pass++;
    endtask

    typedef struct {
        int     w;
        bit     s;
        longint a;
        longint b;
        longint e;
    } vec_t;

    task automatic test_directed();
        vec_t   tbl[8];
        int     lat, nb;
        longint pr;
        tbl[0] = '{0, 1'b0, 13,   11,   143};
        tbl[1] = '{1, 1'b0, 255,  255,  65025};
        tbl[2] = '{1, 1'b0, 0,    200,  0};
        tbl[3] = '{0, 1'b1, 4'hD, 5,    8'hF1};
        tbl[4] = '{0, 1'b1, 4'h8, 4'h8, 8'h40};
        tbl[5] = '{0, 1'b1, 4'h8, 0,    0};
        tbl[6] = '{2, 1'b1, 7,    6'h20, 10'h320};
        tbl[7] = '{2, 1'b0, 15,   63,   945};
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b, lat, nb, pr);
            n_total++;
            if (pr !== tbl[i].e) $display("FAIL directed_%0d_product: got %0d required %0d", i, pr, tbl[i].e);
            else n_pass++;
            n_total++;
            if (lat !== nbits(tbl[i].w) + 2) $display("FAIL directed_%0d_latency: got %0d required %0d", i, lat, nbits(tbl[i].w) + 2);
            else n_pass++;
            n_total++;
            if (nb !== nbits(tbl[i].w) + 2) $display("FAIL directed_%0d_busy_cycles: got %0d required %0d", i, nb, nbits(tbl[i].w) + 2);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (done[tbl[i].w] !== 1'b0 || busy[tbl[i].w] !== 1'b0 || prod_of(tbl[i].w) !== tbl[i].e)
                $display("FAIL directed_%0d_hold: done %b busy %b product %0d required 0 0 %0d",
                         i, done[tbl[i].w], busy[tbl[i].w], prod_of(tbl[i].w), tbl[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int     lat, nb;
        longint pr, a, b, e;
        bit     s;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 8; k++) begin
                s = 1'($urandom_range(0, 1));
                a = longint'($urandom_range(0, (1 << nbits(w)) - 1));
                b = longint'($urandom_range(0, (1 << mbits(w)) - 1));
                e = model(w, s, a, b);
                run_op(w, s, a, b, lat, nb, pr);
                n_total++;
                if (pr !== e || lat !== nbits(w) + 2)
                    $display("FAIL random_w%0d_%0d: s=%0d a=%0d b=%0d got %0d lat %0d required %0d lat %0d",
                             w, k, s, a, b, pr, lat, e, nbits(w) + 2);
                else n_pass++;
            end
        end
    endtask

    // St held high throughout: operands changed mid-operation must not leak
    // into the first result, and the next op starts right after Done.
    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        sg[0] = 1'b0;
        mp0   = 4'd6;
        mc0   = 4'd7;
        st[0] = 1'b1;
        cyc   = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin mp0 = 4'd9; mc0 = 4'd5; end
            if (done[0]) break;
        end
        n_total++;
        if (cyc !== 6 || p0 !== 8'd42) $display("FAIL b2b_first: got lat %0d product %0d required lat 6 product 42", cyc, p0);
        else n_pass++;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done[0]) break;
        end
        st[0] = 1'b0;
        n_total++;
        if (cyc !== 7 || p0 !== 8'd45) $display("FAIL b2b_second: got lat %0d product %0d required lat 7 product 45", cyc, p0);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (busy[0] !== 1'b0) $display("FAIL b2b_idle_after: got busy %b required 0", busy[0]);
        else n_pass++;
    endtask

    task automatic test_abort();
        int     ndone, lat, nb;
        longint pr;
        @(negedge clk);
        set_ops(0, 1'b0, 13, 11);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || p0 !== 8'd0)
            $display("FAIL abort_state: busy %b done %b product %0d required 0 0 0", busy[0], done[0], p0);
        else n_pass++;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        n_total++;
        if (ndone !== 0) $display("FAIL abort_no_done: got %0d done pulses required 0", ndone);
        else n_pass++;
        run_op(0, 1'b0, 2, 3, lat, nb, pr);
        n_total++;
        if (pr !== 64'sd6 || lat !== 6) $display("FAIL abort_fresh_op: got %0d lat %0d required 6 lat 6", pr, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
